// File: rtl/mux_arb_reg.sv
// Registered N:1 channel mux with fixed-select or round-robin arbitration.
// One-word output register with valid/ready handshakes on both sides.
module mux_arb_reg #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;

    assign load_en = !out_valid || out_ready;

    // Grant select; descending scan so the channel closest after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            grant_vld = in_valid[sel];
            grant_idx = sel;
        end else begin
            for (int k = NUM_IN; k >= 1; k--) begin
                if (in_valid[rr_ptr + SEL_W'(k)]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_ptr + SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is forced low during reset so nothing is consumed while held.
    always_comb begin
        in_ready = '0;
        if (reset_n && load_en && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= SEL_W'(NUM_IN - 1);
        end else if (load_en) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data <= grant_data;
                out_src  <= grant_idx;
                rr_ptr   <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted output word.
module tb_mux_arb_reg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 8;
    localparam int unsigned SEL_W  = 3;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_src;

    int vectors     = 0;
    int miscompares = 0;
    logic [SEL_W+WIDTH-1:0] exp_q[$];

    mux_arb_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] chan_val(int i);
        return (i == 0) ? 32'hCAFE_0000 : 32'(i) * 32'h0000_0011;
    endfunction

    function automatic logic [SEL_W+WIDTH-1:0] word(int s);
        return {SEL_W'(s), chan_val(s)};
    endfunction

    function automatic logic [NUM_IN-1:0] onehot(int s);
        return NUM_IN'(1) << s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word visible with valid&ready at negedge is accepted at the next posedge.
    always @(negedge clk) begin
        logic [SEL_W+WIDTH-1:0] e;
        if (reset_n && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard: unexpected word src=%0d data=%0h", out_src, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_src, out_data} !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard: got src=%0d data=%0h expected src=%0d data=%0h",
                             out_src, out_data, e[SEL_W+WIDTH-1:WIDTH], e[WIDTH-1:0]);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = chan_val(i);
        reset_n   = 1'b0;
        in_valid  = 8'hFF;
        mode      = 1'b1;
        sel       = '0;
        out_ready = 1'b1;
        #3;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_data",  64'(out_data),  64'(0));
        chk("reset_out_src",   64'(out_src),   64'(0));
        chk("reset_in_ready",  64'(in_ready),  64'(0));
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // Round-robin from reset, all valid: 0..7,0 back to back.
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("rr_in_ready", 64'(in_ready), 64'(onehot(k % 8)));
            exp_q.push_back(word(k % 8));
            step();
            chk("rr_out_valid", 64'(out_valid), 64'(1));
            chk("rr_out_src",   64'(out_src),   64'(k % 8));
        end
        in_valid = '0;
        step();
        chk("rr_drain_valid", 64'(out_valid), 64'(0));

        // Wrap-around between channels 7 and 0 with rr_ptr at 0.
        in_valid = 8'b1000_0001;
        for (int j = 0; j < 3; j++) begin
            int g;
            g = (j == 1) ? 0 : 7;
            #1;
            chk("wrap_in_ready", 64'(in_ready), 64'(onehot(g)));
            exp_q.push_back(word(g));
            step();
            chk("wrap_out_src", 64'(out_src), 64'(g));
        end
        in_valid = '0;
        step();
        chk("wrap_drain_valid", 64'(out_valid), 64'(0));

        // Fixed select of channel 5.
        mode = 1'b0;
        sel = 3'd5;
        in_valid = 8'hFF;
        #1;
        chk("fixed_in_ready", 64'(in_ready), 64'(8'h20));
        exp_q.push_back(word(5));
        step();
        in_valid = '0;
        chk("fixed_out_valid", 64'(out_valid), 64'(1));
        chk("fixed_out_src",   64'(out_src),   64'(5));
        chk("fixed_out_data",  64'(out_data),  64'(32'h55));
        step();
        chk("fixed_drain_valid", 64'(out_valid), 64'(0));

        // Backpressure: hold word from channel 6 for three cycles.
        mode = 1'b1;
        in_valid = 8'hFF;
        #1;
        chk("bp_first_ready", 64'(in_ready), 64'(8'h40));
        exp_q.push_back(word(6));
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready",  64'(in_ready),  64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_out_src",   64'(out_src),   64'(6));
            chk("bp_out_data",  64'(out_data),  64'(chan_val(6)));
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'(8'h80));
        exp_q.push_back(word(7));
        step();
        chk("bp_next_valid", 64'(out_valid), 64'(1));
        chk("bp_next_src",   64'(out_src),   64'(7));
        in_valid = '0;
        step();
        chk("bp_drain_valid", 64'(out_valid), 64'(0));

        // Fixed select on an idle channel: no grant, held word drains.
        mode = 1'b0;
        sel = 3'd2;
        in_valid = 8'hFF;
        out_ready = 1'b0;
        #1;
        chk("idle_load_ready", 64'(in_ready), 64'(8'h04));
        exp_q.push_back(word(2));
        step();
        in_valid = 8'hFB;
        #1;
        chk("idle_hold_ready", 64'(in_ready), 64'(0));
        step();
        chk("idle_hold_valid", 64'(out_valid), 64'(1));
        chk("idle_hold_src",   64'(out_src),   64'(2));
        out_ready = 1'b1;
        #1;
        chk("idle_no_grant", 64'(in_ready), 64'(0));
        step();
        chk("idle_drop_valid", 64'(out_valid), 64'(0));

        // Asynchronous reset with a held word; restart grants channel 0 first.
        mode = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b0;
        step();
        chk("arst_loaded_valid", 64'(out_valid), 64'(1));
        chk("arst_loaded_src",   64'(out_src),   64'(3));
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_out_data",  64'(out_data),  64'(0));
        chk("arst_out_src",   64'(out_src),   64'(0));
        chk("arst_in_ready",  64'(in_ready),  64'(0));
        step();
        step();
        reset_n = 1'b1;
        in_valid = 8'h81;
        out_ready = 1'b1;
        #1;
        chk("arst_first_ready", 64'(in_ready), 64'(8'h01));
        exp_q.push_back(word(0));
        step();
        chk("arst_first_valid", 64'(out_valid), 64'(1));
        chk("arst_first_src",   64'(out_src),   64'(0));
        in_valid = '0;
        step();
        chk("arst_drain_valid", 64'(out_valid), 64'(0));

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_arb_reg.md
MUX_ARB_REG -- requirements
Module: mux_arb_reg

Interface
REQ-001 Parameter WIDTH, default 32: data width of every input channel and of the output.
REQ-002 Parameter NUM_IN, default 8: number of input channels; legal values 2, 4, 8, 16.
REQ-003 Parameter SEL_W, default 3: select/source width; SHALL equal log2(NUM_IN).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset; asynchronous, active-low.
REQ-006 in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  per-channel valid.
REQ-008 in_ready  output  NUM_IN  per-channel ready; a transfer on channel i occurs when in_valid[i] and in_ready[i] are both 1 at a rising edge.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-010 sel  input  SEL_W  channel index used in fixed-select mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds a word not yet accepted downstream.
REQ-013 out_ready  input  1  downstream accept; a transfer occurs when out_valid and out_ready are both 1 at a rising edge.
REQ-014 out_src  output  SEL_W  channel index that out_data came from.

Function
REQ-015 The output stage SHALL be a single register; load_en = !out_valid || out_ready.
REQ-016 Fixed mode: the grant SHALL be sel when in_valid[sel] = 1; otherwise there SHALL be no grant. Other channels' in_valid SHALL be ignored.
REQ-017 Round-robin mode: the grant SHALL be the first channel with in_valid = 1, searching from (rr_ptr+1) mod NUM_IN upward with wrap-around.
REQ-018 If no channel is valid, there SHALL be no grant.
REQ-019 in_ready[i] SHALL be 1 only when load_en = 1 and channel i is the grant. in_ready is combinational from in_valid, mode, sel, rr_ptr, out_valid and out_ready. At most one in_ready bit SHALL be 1.
REQ-020 On a grant with load_en = 1: out_data SHALL take the granted channel's data, out_src SHALL take the grant index, and out_valid SHALL be 1 on the next cycle. Latency is 1 cycle, input to output.
REQ-021 With load_en = 1 and no grant: out_valid SHALL go to 0 on the next cycle. out_data and out_src SHALL hold their values.
REQ-022 When out_valid = 1 and out_ready = 0: out_data, out_valid and out_src SHALL hold. All in_ready bits SHALL be 0.
REQ-023 Simultaneous output accept and new grant SHALL both complete in the same cycle, giving full throughput of one word per cycle.
REQ-024 rr_ptr SHALL update to the grant index on every completed input transfer, in either mode. Otherwise rr_ptr SHALL hold.
REQ-025 A change to mode or sel SHALL affect only the next grant decision. A word already held in the output register SHALL be unaffected.
REQ-026 An sel value of NUM_IN or more cannot occur, because SEL_W = log2(NUM_IN).

Reset
REQ-027 While reset_n = 0: out_valid = 0, out_data = 0, out_src = 0, rr_ptr = NUM_IN-1 (so channel 0 has first priority). in_ready SHALL be all 0 regardless of other inputs.
REQ-028 Assertion of reset_n mid-transfer SHALL discard the held word immediately, without waiting for a clock edge.
REQ-029 After reset_n deasserts, the first rising edge SHALL behave per REQ-015..REQ-025.

Verification
REQ-030 Fixed mode, sel=5, in_valid=8'hFF, in_data ch5=32'h0000_0055, out_ready=1 -> in_ready=8'h20; the next cycle gives out_valid=1, out_data=32'h55, out_src=5.
REQ-031 Round-robin from reset, all 8 valid continuously, out_ready=1 -> out_src sequence is 0,1,2,...,7,0 on consecutive cycles, with no bubbles.
REQ-032 Backpressure: out_valid=1 and out_ready=0 for 3 cycles -> out_data and out_src stable and in_ready=0 during those cycles. When out_ready rises, the accept and the next load complete in the same cycle.
REQ-033 Round-robin with in_valid=8'b1000_0001 and rr_ptr=0 -> grant is 7, then 0, then 7 (wrap-around).
REQ-034 Fixed mode, sel=2, in_valid[2]=0, other bits 1 -> no in_ready bit set; out_valid drops to 0 after the held word is accepted.
REQ-035 reset_n pulled low between clock edges while out_valid=1 -> out_valid=0, out_data=0 and in_ready=0 immediately. After release, round-robin grants channel 0 first.
